// File: rtl/pipe_seq_pkg.sv
// Shared definitions for the pipeline sequencer slice.
//   - State encoding constants (visible on state_o)
//   - NOP instruction word loaded into IF/ID on a flush
//   - Default counter width
package pipe_seq_pkg;

  localparam logic [2:0] ST_BOOT   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_HALTED = 3'd3;
  localparam logic [2:0] ST_STEP   = 3'd4;

  localparam logic [7:0] NOP_INSTR = 8'h00;

  localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/pipe_valid_tracker.sv
// Occupancy tracker for the ID, EX and WB stages of the 4-stage core.
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   i_ifid_en         IF/ID register loads this cycle
//   i_pc_en           PC advances this cycle (a real fetch happens)
//   i_ifid_flush      IF/ID loads a NOP instead of the fetched word
//   i_idex_bubble     ID/EX loads a NOP
//   i_stall_eff       qualified hazard stall (ID instruction held)
//   o_v_id/ex/wb      current stage valid bits
//   o_v_*_nxt         values the valid bits take at the next edge
//   o_retire          an instruction completes WB this cycle
module pipe_valid_tracker (
  input  logic clk,
  input  logic rst,
  input  logic i_ifid_en,
  input  logic i_pc_en,
  input  logic i_ifid_flush,
  input  logic i_idex_bubble,
  input  logic i_stall_eff,
  output logic o_v_id,
  output logic o_v_ex,
  output logic o_v_wb,
  output logic o_v_id_nxt,
  output logic o_v_ex_nxt,
  output logic o_v_wb_nxt,
  output logic o_retire
);

  logic r_v_id;
  logic r_v_ex;
  logic r_v_wb;
  logic w_v_id_nxt;
  logic w_v_ex_nxt;
  logic w_v_wb_nxt;

  always_comb begin
    w_v_wb_nxt = r_v_ex;
    // A stalled ID instruction stays put, so nothing moves into EX.
    w_v_ex_nxt = r_v_id & ~i_idex_bubble & ~i_stall_eff;
    // IF/ID only holds a real instruction if the PC actually fetched
    // and the word was not replaced by a NOP.
    w_v_id_nxt = i_ifid_en ? (i_pc_en & ~i_ifid_flush) : r_v_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_id <= 1'b0;
      r_v_ex <= 1'b0;
      r_v_wb <= 1'b0;
    end else begin
      r_v_id <= w_v_id_nxt;
      r_v_ex <= w_v_ex_nxt;
      r_v_wb <= w_v_wb_nxt;
    end
  end

  assign o_v_id     = r_v_id;
  assign o_v_ex     = r_v_ex;
  assign o_v_wb     = r_v_wb;
  assign o_v_id_nxt = w_v_id_nxt;
  assign o_v_ex_nxt = w_v_ex_nxt;
  assign o_v_wb_nxt = w_v_wb_nxt;
  assign o_retire   = r_v_wb;

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller for the 8-bit, 4-stage (IF/ID/EX/WB) core.
// Sequences boot hold-off, jump squashing, hazard stalls and debug
// halt / drain / single-step / resume; counts active cycles and retires.
// Ports:
//   clk, rst                core clock, synchronous active-high reset
//   jump_id                 jump decoded in ID
//   hazard_stall            hold PC and IF/ID for one cycle
//   halt_req/step_req/resume_req  debug command pulses
//   pc_en, ifid_en          PC / IF/ID load enables
//   ifid_flush              IF/ID loads NOP_INSTR
//   idex_bubble             ID/EX loads a NOP
//   halted                  halted with an empty pipeline
//   state_o                 current state encoding
//   cycle_cnt, retire_cnt   active-cycle and retired-instruction counters
module pipeline_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES = 2,
  parameter int unsigned CNT_W             = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_id,
  input  logic             hazard_stall,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             resume_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned BOOT_W =
    (RESET_HOLD_CYCLES < 2) ? 1 : $clog2(RESET_HOLD_CYCLES + 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [BOOT_W-1:0] r_boot_cnt;
  logic              r_pend_halt;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic w_v_id;
  logic w_v_ex;
  logic w_v_wb;
  logic w_v_id_nxt;
  logic w_v_ex_nxt;
  logic w_v_wb_nxt;
  logic w_retire;
  logic w_jump_eff;
  logic w_stall_eff;
  logic w_boot_done;
  logic w_active;

  pipe_valid_tracker u_valid (
    .clk           (clk),
    .rst           (rst),
    .i_ifid_en     (ifid_en),
    .i_pc_en       (pc_en),
    .i_ifid_flush  (ifid_flush),
    .i_idex_bubble (idex_bubble),
    .i_stall_eff   (w_stall_eff),
    .o_v_id        (w_v_id),
    .o_v_ex        (w_v_ex),
    .o_v_wb        (w_v_wb),
    .o_v_id_nxt    (w_v_id_nxt),
    .o_v_ex_nxt    (w_v_ex_nxt),
    .o_v_wb_nxt    (w_v_wb_nxt),
    .o_retire      (w_retire)
  );

  // Jump/stall requests only matter when ID holds a real instruction.
  assign w_jump_eff  = jump_id & w_v_id;
  assign w_stall_eff = hazard_stall & w_v_id;

  assign w_boot_done = (32'(r_boot_cnt) + 32'd1) >= RESET_HOLD_CYCLES;
  assign w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN) ||
                       (r_state == ST_STEP);

  // Output decode; stall takes priority over jump in every fetching state.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    case (r_state)
      ST_RUN, ST_STEP: begin
        if (w_stall_eff) begin
          idex_bubble = 1'b1;
        end else begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = w_jump_eff;
        end
      end
      ST_DRAIN: begin
        if (w_stall_eff) begin
          idex_bubble = 1'b1;
        end else begin
          // IF/ID empties while ID advances; a jump still updates the PC.
          pc_en      = w_jump_eff;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end
      end
      ST_HALTED: begin
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: begin
        if (w_boot_done) begin
          w_state_nxt = (r_pend_halt | halt_req) ? ST_HALTED : ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Exit only once the pipeline will be empty after this edge.
        if (!(w_v_id_nxt | w_v_ex_nxt | w_v_wb_nxt)) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (resume_req) begin
          w_state_nxt = ST_RUN;
        end else if (step_req) begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        w_state_nxt = ST_DRAIN;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_boot_cnt   <= '0;
      r_pend_halt  <= 1'b0;
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_BOOT) begin
        r_boot_cnt  <= w_boot_done ? r_boot_cnt : r_boot_cnt + 1'b1;
        r_pend_halt <= w_boot_done ? 1'b0 : (r_pend_halt | halt_req);
      end else begin
        r_pend_halt <= 1'b0;
      end
      if (w_active) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + 1'b1;
      end
    end
  end

  assign state_o    = r_state;
  assign cycle_cnt  = r_cycle_cnt;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

  localparam int HOLD = 2;

  // Architectural modes, numbered as the state_o encoding.
  localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3, M_STEP = 4;
  // What the pipeline front end does in a cycle.
  localparam int A_BOOT = 0, A_IDLE = 1, A_HOLD = 2, A_FETCH = 3,
                 A_SQUASH = 4, A_FLUSH = 5;

  typedef struct {
    bit pc_en;
    bit ifid_en;
    bit flush;
    bit bubble;
    bit halted;
    int state;
    int cyc;
    int ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_id = 1'b0;
  logic        hazard_stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic        resume_req = 1'b0;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        halted;
  logic [2:0]  state_o;
  logic [15:0] cycle_cnt;
  logic [15:0] retire_cnt;

  pipeline_sequencer #(.RESET_HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_id      (jump_id),
    .hazard_stall (hazard_stall),
    .halt_req     (halt_req),
    .step_req     (step_req),
    .resume_req   (resume_req),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .halted       (halted),
    .state_o      (state_o),
    .cycle_cnt    (cycle_cnt),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: instruction serial numbers sitting in ID/EX/WB (0 = empty).
  int          m_mode;
  int          m_boot_left;
  bit          m_pend;
  int          m_id, m_ex, m_wb;
  int          m_serial;
  logic [15:0] m_cyc, m_ret;

  task automatic cmp(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_boot_left = HOLD; m_pend = 0;
    m_id = 0; m_ex = 0; m_wb = 0;
    m_cyc = '0; m_ret = '0;
  endtask

  task automatic model_cycle(input bit r, j, s, h, st, rs, output exp_t e);
    int  act;
    bit  busy;
    int  nid, nex;
    busy = (m_id != 0);
    case (m_mode)
      M_BOOT:   act = A_BOOT;
      M_HALTED: act = A_IDLE;
      M_DRAIN:  act = (s && busy) ? A_HOLD : (j && busy) ? A_SQUASH : A_FLUSH;
      default:  act = (s && busy) ? A_HOLD : (j && busy) ? A_SQUASH : A_FETCH;
    endcase
    e.pc_en   = (act == A_FETCH) || (act == A_SQUASH);
    e.ifid_en = (act == A_FETCH) || (act == A_SQUASH) || (act == A_FLUSH);
    e.flush   = (act == A_BOOT) || (act == A_SQUASH) || (act == A_FLUSH);
    e.bubble  = (act == A_BOOT) || (act == A_IDLE) || (act == A_HOLD);
    e.halted  = (m_mode == M_HALTED);
    e.state   = m_mode;
    e.cyc     = int'(m_cyc);
    e.ret     = int'(m_ret);

    if (r) begin
      model_reset();
      return;
    end
    if (m_wb != 0) m_ret++;
    if (m_mode == M_RUN || m_mode == M_DRAIN || m_mode == M_STEP) m_cyc++;

    nex = (act == A_FETCH || act == A_SQUASH || act == A_FLUSH) ? m_id : 0;
    if (act == A_FETCH) begin
      m_serial++;
      nid = m_serial;
    end else if (act == A_SQUASH || act == A_FLUSH) begin
      nid = 0;
    end else begin
      nid = m_id;
    end
    m_wb = m_ex; m_ex = nex; m_id = nid;

    case (m_mode)
      M_BOOT: begin
        if (h) m_pend = 1;
        m_boot_left--;
        if (m_boot_left <= 0) begin
          m_mode = m_pend ? M_HALTED : M_RUN;
          m_pend = 0;
        end
      end
      M_RUN:    if (h) m_mode = M_DRAIN;
      M_DRAIN:  if (m_id == 0 && m_ex == 0 && m_wb == 0) m_mode = M_HALTED;
      M_HALTED: begin
        if (rs) m_mode = M_RUN;
        else if (st) m_mode = M_STEP;
      end
      default:  m_mode = M_DRAIN;
    endcase
  endtask

  // Called at posedge+1: drive one cycle of inputs, log expectation, advance.
  task automatic tick(input bit r, j, s, h, st, rs);
    exp_t e;
    rst = r; jump_id = j; hazard_stall = s;
    halt_req = h; step_req = st; resume_req = rs;
    model_cycle(r, j, s, h, st, rs, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("pc_en",       int'(pc_en),       int'(e.pc_en));
        cmp("ifid_en",     int'(ifid_en),     int'(e.ifid_en));
        cmp("ifid_flush",  int'(ifid_flush),  int'(e.flush));
        cmp("idex_bubble", int'(idex_bubble), int'(e.bubble));
        cmp("halted",      int'(halted),      int'(e.halted));
        cmp("state_o",     int'(state_o),     e.state);
        cmp("cycle_cnt",   int'(cycle_cnt),   e.cyc);
        cmp("retire_cnt",  int'(retire_cnt),  e.ret);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int r0, c0;
    m_serial = 0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held three cycles, then boot hold-off.
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    cmp("rst_state", int'(state_o), 0);
    cmp("rst_cycle", int'(cycle_cnt), 0);
    cmp("rst_retire", int'(retire_cnt), 0);
    tick(0, 0, 0, 0, 0, 0);
    cmp("boot_hold", int'(state_o), 0);
    tick(0, 0, 0, 0, 0, 0);
    cmp("boot_exit", int'(state_o), 1);

    // Straight-line run.
    idle(10);
    cmp("straight_cycle", int'(cycle_cnt), 10);
    cmp("straight_retire", int'(retire_cnt), 7);

    // Jump on the 5th run cycle after a fresh reset.
    tick(1, 0, 0, 0, 0, 0);
    idle(2);
    idle(4);
    tick(0, 1, 0, 0, 0, 0);
    idle(5);
    cmp("jump_cycle", int'(cycle_cnt), 10);
    cmp("jump_retire", int'(retire_cnt), 6);

    // One-cycle stall with a jump that must not be taken.
    r0 = int'(retire_cnt);
    tick(0, 1, 1, 0, 0, 0);
    idle(9);
    cmp("stall_retire_delta", int'(retire_cnt) - r0, 9);

    // Halt from RUN.
    tick(0, 0, 0, 1, 0, 0);
    cmp("halt_drain_state", int'(state_o), 2);
    for (int k = 0; k < 4 && !halted; k++) idle(1);
    cmp("halt_latency", int'(halted), 1);
    r0 = int'(retire_cnt);
    c0 = int'(cycle_cnt);
    idle(3);
    cmp("halt_retire_frozen", int'(retire_cnt), r0);
    cmp("halt_cycle_frozen", int'(cycle_cnt), c0);

    // Single step.
    tick(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 8 && !halted; k++) idle(1);
    cmp("step_retire", int'(retire_cnt), r0 + 1);
    cmp("step_halted", int'(halted), 1);

    // Step and resume together.
    tick(0, 0, 0, 0, 1, 1);
    cmp("step_resume_state", int'(state_o), 1);

    // Reset during drain.
    tick(0, 0, 0, 1, 0, 0);
    cmp("drain_state", int'(state_o), 2);
    tick(1, 0, 0, 0, 0, 0);
    cmp("drain_rst_state", int'(state_o), 0);
    cmp("drain_rst_cycle", int'(cycle_cnt), 0);
    cmp("drain_rst_retire", int'(retire_cnt), 0);

    // Halt during boot: straight to HALTED, no fetch.
    tick(0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    cmp("boot_halt_state", int'(state_o), 3);
    idle(3);
    cmp("boot_halt_cycle", int'(cycle_cnt), 0);
    cmp("boot_halt_retire", int'(retire_cnt), 0);
    tick(0, 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 6);
    end
    idle(2);

    #20;
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central pipeline controller for the 8-bit, 4-stage core (IF, ID, EX, WB).
- Drives the PC enable, the IF/ID enable/flush and the ID/EX bubble insert. Sequences boot hold-off, jump squashing, hazard stalls, and debug halt/drain/single-step/resume.
- Tracks per-stage occupancy so halts complete only on an empty pipeline, and counts cycles and retired instructions.

Parameters:
- RESET_HOLD_CYCLES, 2: cycles after reset release before the first fetch, covering instruction-memory reset.
- CNT_W, 16: width of the cycle and retire counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- jump_id  in  1  jump decoded in ID this cycle (the core's jump decode).
- hazard_stall  in  1  hold IF/ID and PC one cycle; request comes from hazard detection.
- halt_req  in  1  debug halt pulse.
- step_req  in  1  debug single-step pulse.
- resume_req  in  1  debug resume pulse.
- pc_en  out  1  PC loads next or jump target.
- ifid_en  out  1  IF/ID register loads.
- ifid_flush  out  1  IF/ID loads NOP (8'h00) instead of the fetched instruction.
- idex_bubble  out  1  ID/EX loads NOP/zero controls.
- halted  out  1  core halted with an empty pipeline.
- state_o  out  3  current state encoding.
- cycle_cnt  out  CNT_W  active-cycle counter.
- retire_cnt  out  CNT_W  retired-instruction counter.

Behaviour:
- Registered state: FSM state, boot counter, v_id/v_ex/v_wb valid bits, both counters, pending-halt flag.
- Outputs are combinational decode of the registered state plus jump_id and hazard_stall.
- Reset (rst=1 at clk edge), applied next cycle from any state including mid-drain:
  - state=BOOT, boot counter=0, valids=0, counters=0, pending-halt=0.
  - Outputs: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, halted=0.
- Qualified inputs: jump_eff=jump_id&v_id, stall_eff=hazard_stall&v_id. Stall has priority over jump; a jump under stall is taken when re-presented.
- Valid pipeline, every cycle:
  - v_wb<=v_ex.
  - v_ex<=v_id&~idex_bubble&~stall_eff.
  - v_id<=ifid_en ? (pc_en&~ifid_flush) : v_id.
- Retire: v_wb=1 means retire_cnt+1. Both counters wrap modulo 2^CNT_W.
- cycle_cnt increments in RUN, DRAIN and STEP only.
- States (state_o encoding: BOOT=0, RUN=1, DRAIN=2, HALTED=3, STEP=4):
  - BOOT: outputs as reset. After RESET_HOLD_CYCLES cycles go to HALTED if pending-halt is set, else RUN. halt_req in BOOT sets pending-halt.
  - RUN, normal: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
  - RUN, jump_eff: additionally ifid_flush=1 (squash the sequential fetch; PC loads the target).
  - RUN, stall_eff: pc_en=0, ifid_en=0, idex_bubble=1.
  - RUN, halt_req: go to DRAIN next cycle. resume_req/step_req are ignored.
  - DRAIN, default: pc_en=0, ifid_en=1, ifid_flush=1 (the ID instruction advances, IF/ID empties).
  - DRAIN, jump_eff: pc_en=1 so the jump is not lost.
  - DRAIN, stall_eff: handled as in RUN.
  - DRAIN exit: go to HALTED when v_id|v_ex|v_wb=0, evaluated on next-state values.
  - HALTED: pc_en=0, ifid_en=0, idex_bubble=1, halted=1.
    - resume_req: go to RUN.
    - step_req alone: go to STEP.
    - step_req and resume_req together: resume wins.
    - halt_req is ignored.
  - STEP: exactly one fetch cycle (RUN outputs, no halt check), then DRAIN. Net result is one instruction retired.
- Latency:
  - An instruction fetched at cycle t retires (v_wb=1) at t+3.
  - Halt from RUN: halted rises no later than 4 cycles after halt_req, absent stalls.

Decomposition:
- Package pipe_seq_pkg holds:
  - the state encoding constants;
  - NOP_INSTR=8'h00;
  - the default CNT_W.
- Sub-module pipe_valid_tracker holds the v_id/v_ex/v_wb shift logic and the retire pulse.

Test Plan:
- Reset: rst=1 for 3 cycles, then release with RESET_HOLD_CYCLES=2 -> pc_en=0 and state_o=0 for 2 cycles; state_o=1 and pc_en=1 on the 3rd; counters=0.
- Straight-line: 10 RUN cycles, no jump or stall -> cycle_cnt=10, retire_cnt=7 (first retire at cycle 4).
- Jump: jump_id=1 while v_id=1 -> same cycle pc_en=1 and ifid_flush=1; 10 RUN cycles with one jump give retire_cnt=6.
- Stall: hazard_stall=1 for 1 cycle with v_id=1 -> pc_en=0, ifid_en=0, idex_bubble=1; retire sequence shows one gap; jump_id asserted in the same cycle is not taken.
- Halt/step/resume:
  - halt_req in RUN -> state 2, then halted=1 within 4 cycles, and retire_cnt then frozen.
  - step_req -> retire_cnt+1 exactly, halted=1 again.
  - resume_req -> state 1.
- Corner cases:
  - step_req and resume_req together in HALTED -> RUN.
  - rst during DRAIN -> next cycle state_o=0 and counters=0.
  - halt_req during BOOT -> HALTED directly after hold-off, with no fetch.
